// File: rtl/sid_dac_sequencer.sv
// sid_dac_sequencer: dual 12-bit serial DAC frame sequencer; SID_DAC_OFFSET_BIN_EN inverts sample MSBs at capture
module sid_dac_sequencer #(
  parameter int WIDTH = 12,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_1,
  input  logic [WIDTH-1:0] sample_2,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             busy,
  output logic             DAC_clk,
  output logic             DAC_dat_1,
  output logic             DAC_dat_2,
  output logic             DAC_csb,
  output logic             DAC_leb
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END, S_LATCH} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, n_cnt;
  logic [BW-1:0] bit_idx, n_bit;
  logic [WIDTH-1:0] sh_1, sh_2, n_sh_1, n_sh_2, cap_1, cap_2;
  logic phase, n_phase, accept, tick, last, adv;
  logic n_dac_clk, n_dat_1, n_dat_2, n_csb, n_leb, n_ready, n_busy;
`ifdef SID_DAC_OFFSET_BIN_EN
  assign cap_1 = sample_1 ^ {1'b1, {(WIDTH-1){1'b0}}};
  assign cap_2 = sample_2 ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
  assign cap_1 = sample_1;
  assign cap_2 = sample_2;
`endif
  assign accept = sample_valid & sample_ready;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign adv = (state == S_SHIFT) & tick & phase;
  assign last = adv & (bit_idx == '0);
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : nstate;
  // next-state: each non-idle state lasts a whole number of ticks
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  nstate = accept ? S_SHIFT : S_IDLE;
      S_SHIFT: nstate = last ? S_END : S_SHIFT;
      S_END:   nstate = tick ? S_LATCH : S_END;
      default: nstate = tick ? S_IDLE : S_LATCH;
    endcase
  end
  // datapath next values: divider, clock phase, bit index and shift registers
  always_comb begin
    n_cnt = (state == S_IDLE || tick) ? '0 : cnt + 1'b1;
    n_phase = (state == S_SHIFT) & (phase ^ tick);
    n_bit = accept ? BW'(WIDTH - 1) : adv ? bit_idx - 1'b1 : bit_idx;
    n_sh_1 = accept ? cap_1 : adv ? sh_1 << 1 : sh_1;
    n_sh_2 = accept ? cap_2 : adv ? sh_2 << 1 : sh_2;
  end
  // outputs derived from next state so that the pins come straight from flops
  always_comb begin
    n_dac_clk = (nstate == S_SHIFT) & n_phase;
    n_dat_1 = (nstate == S_SHIFT) & n_sh_1[WIDTH-1];
    n_dat_2 = (nstate == S_SHIFT) & n_sh_2[WIDTH-1];
    n_csb = nstate != S_SHIFT;
    n_leb = nstate != S_LATCH;
    n_ready = nstate == S_IDLE;
    n_busy = nstate != S_IDLE;
  end
  // datapath and output registers
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      phase <= 1'b0;
      bit_idx <= '0;
      sh_1 <= '0;
      sh_2 <= '0;
      DAC_clk <= 1'b0;
      DAC_dat_1 <= 1'b0;
      DAC_dat_2 <= 1'b0;
      DAC_csb <= 1'b1;
      DAC_leb <= 1'b1;
      sample_ready <= 1'b1;
      busy <= 1'b0;
    end else begin
      cnt <= n_cnt;
      phase <= n_phase;
      bit_idx <= n_bit;
      sh_1 <= n_sh_1;
      sh_2 <= n_sh_2;
      DAC_clk <= n_dac_clk;
      DAC_dat_1 <= n_dat_1;
      DAC_dat_2 <= n_dat_2;
      DAC_csb <= n_csb;
      DAC_leb <= n_leb;
      sample_ready <= n_ready;
      busy <= n_busy;
    end
endmodule

// File: tb/tb_sid_dac_sequencer.sv
// tb_sid_dac_sequencer: random and directed frames on CLK_DIV=4 and CLK_DIV=1 instances against a timing model
module tb_sid_dac_sequencer;
  localparam int W = 12;
`ifdef SID_DAC_OFFSET_BIN_EN
  localparam logic [W-1:0] XM = 12'h800;
`else
  localparam logic [W-1:0] XM = 12'h000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] s1[2], s2[2];
  logic v[2], rdy[2], bsy[2], dclk[2], d1[2], d2[2], csb[2], leb[2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sid_dac_sequencer #(.WIDTH(W), .CLK_DIV(g == 0 ? 4 : 1)) u_dut (
      .clk(clk), .rst(rst), .sample_1(s1[g]), .sample_2(s2[g]), .sample_valid(v[g]),
      .sample_ready(rdy[g]), .busy(bsy[g]), .DAC_clk(dclk[g]), .DAC_dat_1(d1[g]),
      .DAC_dat_2(d2[g]), .DAC_csb(csb[g]), .DAC_leb(leb[g])
    );
  end
  int n_cmp = 0, n_bad = 0;
  int rem[2] = '{0, 0};
  int frames[2] = '{0, 0};
  int nb[2] = '{0, 0};
  int lebs[2] = '{0, 0};
  logic [W-1:0] c1[2], c2[2], done1[2], done2[2], rx1[2], rx2[2], last1[2], last2[2];
  logic pclk[2] = '{1'b0, 1'b0};
  logic pcsb[2] = '{1'b1, 1'b1};
  logic pleb[2] = '{1'b1, 1'b1};
  bit armed = 1'b0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] outs(int d);
    return {rdy[d], bsy[d], dclk[d], d1[d], d2[d], csb[d], leb[d]};
  endfunction
  function automatic logic [6:0] model_outs(int d);
    int div, k, idx;
    div = d == 0 ? 4 : 1;
    if (rem[d] == 0) return 7'b1000011;
    k = 26 * div - rem[d];
    if (rem[d] <= 2 * div) return {5'b01000, 1'b1, rem[d] > div};
    idx = W - 1 - k / (2 * div);
    return {2'b01, ((k / div) % 2) == 1, c1[d][idx], c2[d][idx], 2'b01};
  endfunction
  task automatic step();
    @(negedge clk);
    if (rst) armed = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) rem[d] = 0;
      else if (rem[d] == 0 && v[d]) begin
        c1[d] = s1[d] ^ XM;
        c2[d] = s2[d] ^ XM;
        rem[d] = 26 * (d == 0 ? 4 : 1);
      end else if (rem[d] > 0) begin
        rem[d]--;
        if (rem[d] == 0) begin
          frames[d]++;
          done1[d] = c1[d];
          done2[d] = c2[d];
        end
      end
      if (armed) begin
        chk($sformatf("outs%0d", d), 32'(outs(d)), 32'(model_outs(d)));
        if (!csb[d] && pcsb[d]) begin
          nb[d] = 0;
          rx1[d] = '0;
          rx2[d] = '0;
        end
        if (dclk[d] && !pclk[d] && !csb[d]) begin
          rx1[d] = {rx1[d][W-2:0], d1[d]};
          rx2[d] = {rx2[d][W-2:0], d2[d]};
          nb[d]++;
        end
        if (!leb[d] && pleb[d]) begin
          lebs[d]++;
          last1[d] = rx1[d];
          last2[d] = rx2[d];
        end
        pclk[d] = dclk[d];
        pcsb[d] = csb[d];
        pleb[d] = leb[d];
      end
    end
  endtask
  task automatic wait_ready(int d, int lim, output int n);
    n = 0;
    while (rdy[d] !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk($sformatf("ready_wait%0d", d), 32'(rdy[d]), 1);
  endtask
  task automatic send(int d, logic [W-1:0] a, logic [W-1:0] b);
    int n;
    wait_ready(d, 200, n);
    s1[d] = a;
    s2[d] = b;
    v[d] = 1'b1;
    step();
    v[d] = 1'b0;
  endtask
  initial begin
    int n, l0;
    logic [W-1:0] a, b;
    for (int d = 0; d < 2; d++) begin
      s1[d] = '0;
      s2[d] = '0;
      v[d] = 1'b0;
    end
    rst = 1'b1;
    step();
    step();
    chk("rst_outs0", 32'(outs(0)), 32'h43);
    chk("rst_outs1", 32'(outs(1)), 32'h43);
    rst = 1'b0;
    send(0, 12'hA5C, 12'h3F0);
    wait_ready(0, 200, n);
    chk("t2_len", n, 104);
    chk("t2_dat1", 32'(last1[0]), 32'(12'hA5C ^ XM));
    chk("t2_dat2", 32'(last2[0]), 32'(12'h3F0 ^ XM));
    l0 = lebs[0];
    v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready(0, 200, n);
      a = W'($urandom);
      b = W'($urandom);
      s1[0] = a;
      s2[0] = b;
      step();
    end
    v[0] = 1'b0;
    wait_ready(0, 200, n);
    chk("t3_lebs", lebs[0] - l0, 3);
    chk("t3_dat1", 32'(last1[0]), 32'(a ^ XM));
    chk("t3_dat2", 32'(last2[0]), 32'(b ^ XM));
    send(0, 12'hA5C, 12'h123);
    repeat (30) step();
    s1[0] = 12'hFFF;
    v[0] = 1'b1;
    wait_ready(0, 200, n);
    chk("t4_dat1", 32'(last1[0]), 32'(12'hA5C ^ XM));
    step();
    v[0] = 1'b0;
    wait_ready(0, 200, n);
    chk("t4_next", 32'(last1[0]), 32'(12'hFFF ^ XM));
    send(0, W'($urandom), W'($urandom));
    l0 = lebs[0];
    for (int k = 0; k < 200 && nb[0] < 5; k++) step();
    chk("t5_rises", nb[0], 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_csb", 32'(csb[0]), 1);
    chk("t5_rdy", 32'(rdy[0]), 1);
    repeat (120) step();
    chk("t5_noleb", lebs[0], l0);
    a = W'($urandom);
    b = W'($urandom);
    send(0, a, b);
    wait_ready(0, 200, n);
    chk("t5_dat1", 32'(last1[0]), 32'(a ^ XM));
    chk("t5_dat2", 32'(last2[0]), 32'(b ^ XM));
    send(1, 12'h800, 12'h7FF);
    wait_ready(1, 60, n);
    chk("t6_len", n, 26);
    chk("t6_dat1", 32'(last1[1]), 32'(12'h800 ^ XM));
    chk("t6_dat2", 32'(last2[1]), 32'(12'h7FF ^ XM));
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0) begin
          s1[d] = W'($urandom);
          s2[d] = W'($urandom);
        end
        v[d] = 1'($urandom_range(0, 1));
      end
      step();
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wait_ready(d, 200, n);
      chk($sformatf("rnd_frames%0d", d), lebs[d], frames[d]);
      chk($sformatf("rnd_dat1_%0d", d), 32'(last1[d]), 32'(done1[d]));
      chk($sformatf("rnd_dat2_%0d", d), 32'(last2[d]), 32'(done2[d]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
